// File: rtl/magia_eu_obi_initiator.sv
// -----------------------------------------------------------------------------
// magia_eu_obi_initiator
//
// Purpose:
//   A hardware engine, such as an accelerator sync controller or a DMA
//   completion notifier, uses this OBI initiator to raise or clear Event Unit
//   events without help from core software. Each command becomes one
//   single-beat register read or write. The command's byte offset is turned
//   into an absolute address inside the Event Unit window. The block runs the
//   OBI A/R handshake and returns the read data and the error status on a
//   valid/ready response channel. Only one transaction is outstanding at a
//   time.
//
// Optional feature (compile-time macro MAGIA_EU_INIT_TIMEOUT_EN):
//   Defining the macro adds a watchdog that aborts a transaction after
//   TIMEOUT_CYCLES cycles spent in REQ+WAIT. If the abort happens in WAIT, the
//   response that arrives late from the slave is absorbed silently. Without
//   the macro the FSM waits indefinitely and timeout_o is tied low.
//
// Ports:
//   clk_i, rst_i      clock; synchronous active-high reset
//   cmd_valid_i       command valid
//   cmd_ready_o       command ready (high only in IDLE)
//   cmd_we_i          1 = write, 0 = read
//   cmd_offset_i      byte offset from EU_BASE_ADDR
//   cmd_wdata_i       write data
//   cmd_be_i          byte enables
//   rsp_valid_o       response valid
//   rsp_ready_i       response consumed
//   rsp_rdata_o       read data (0 for writes and errors)
//   rsp_err_o         bus error, range error or timeout
//   obi_req_o         OBI request channel (req, a.addr/we/be/wdata)
//   obi_rsp_i         OBI response channel (gnt, rvalid, r.rdata/err)
//   proto_err_o       sticky: unsolicited rvalid observed
//   timeout_o         sticky: a transaction timed out
// -----------------------------------------------------------------------------

package magia_pkg;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [3:0]        be;
      logic [DATA_W-1:0] wdata;
   } core_obi_data_a_t;

   typedef struct packed {
      logic             req;
      core_obi_data_a_t a;
   } core_obi_data_req_t;

   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              err;
   } core_obi_data_r_t;

   typedef struct packed {
      logic             gnt;
      logic             rvalid;
      core_obi_data_r_t r;
   } core_obi_data_rsp_t;
endpackage

package magia_tile_pkg;
   localparam logic [magia_pkg::ADDR_W-1:0] EVENT_UNIT_ADDR_START = 32'h0000_1000;
   localparam logic [magia_pkg::ADDR_W-1:0] EVENT_UNIT_ADDR_END   = 32'h0000_10FF;
endpackage

module magia_eu_obi_initiator #(
   parameter logic [magia_pkg::ADDR_W-1:0] EU_BASE_ADDR   = magia_tile_pkg::EVENT_UNIT_ADDR_START,
   parameter logic [magia_pkg::ADDR_W-1:0] EU_SIZE        = magia_tile_pkg::EVENT_UNIT_ADDR_END
                                                          - magia_tile_pkg::EVENT_UNIT_ADDR_START
                                                          + 32'd1,
   parameter int unsigned                  TIMEOUT_CYCLES = 1024,
   parameter int unsigned                  TO_CNT_W       = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               cmd_valid_i,
   output logic                               cmd_ready_o,
   input  logic                               cmd_we_i,
   input  logic [magia_pkg::ADDR_W-1:0]       cmd_offset_i,
   input  logic [31:0]                        cmd_wdata_i,
   input  logic [3:0]                         cmd_be_i,
   output logic                               rsp_valid_o,
   input  logic                               rsp_ready_i,
   output logic [31:0]                        rsp_rdata_o,
   output logic                               rsp_err_o,
   output magia_pkg::core_obi_data_req_t      obi_req_o,
   input  magia_pkg::core_obi_data_rsp_t      obi_rsp_i,
   output logic                               proto_err_o,
   output logic                               timeout_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RSP  = 2'd3
   } state_t;

   state_t                        r_state;
   state_t                        w_next_state;

   logic                          r_we;
   logic [magia_pkg::ADDR_W-1:0]  r_offset;
   logic [31:0]                   r_wdata;
   logic [3:0]                    r_be;
   logic [31:0]                   r_rdata;
   logic                          r_err;
   logic                          r_proto_err;

   logic                          w_cmd_ready;
   logic                          w_obi_req;
   logic                          w_rsp_valid;
   logic                          w_accept;
   logic                          w_range_err;
   logic                          w_rvalid_done;
   logic                          w_timeout_hit;
   logic                          w_unsolicited;
   logic                          w_absorb;
   logic                          w_to_expired;

   // An offset is rejected locally when it falls outside the window or is not
   // word aligned. Checking it here keeps EU_BASE_ADDR + offset from wrapping.
   assign w_range_err = (cmd_offset_i >= EU_SIZE) || (cmd_offset_i[1:0] != 2'b00);

`ifdef MAGIA_EU_INIT_TIMEOUT_EN
   logic [TO_CNT_W-1:0]           r_to_cnt;
   logic                          r_drop_pending;
   logic                          r_timeout;

   // The counter value equals the number of cycles already spent in REQ+WAIT,
   // so the abort fires on the TIMEOUT_CYCLES-th such cycle. Once an aborted
   // WAIT has set the drop flag, the first rvalid that follows belongs to the
   // abandoned transaction and is swallowed, whatever state the FSM is in.
   assign w_to_expired = (r_to_cnt >= TO_CNT_W'(TIMEOUT_CYCLES - 1));
   assign w_absorb     = obi_rsp_i.rvalid && r_drop_pending;
   assign timeout_o    = r_timeout;

   // The counter clears when a command is launched toward REQ and counts
   // every cycle in REQ or WAIT. The drop flag is set by a timeout in WAIT and
   // cleared once the late response it covers has been absorbed.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_to_cnt       <= '0;
         r_drop_pending <= 1'b0;
         r_timeout      <= 1'b0;
      end else begin
         if (w_accept && !w_range_err) begin
            r_to_cnt <= '0;
         end else if ((r_state == REQ) || (r_state == WAIT)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end
         if (w_timeout_hit && (r_state == WAIT)) begin
            r_drop_pending <= 1'b1;
         end else if (w_absorb) begin
            r_drop_pending <= 1'b0;
         end
         if (w_timeout_hit) begin
            r_timeout <= 1'b1;
         end
      end
   end
`else
   logic                          w_unused_params;

   assign w_to_expired    = 1'b0;
   assign w_absorb        = 1'b0;
   assign timeout_o       = 1'b0;
   assign w_unused_params = (TIMEOUT_CYCLES < 2) ^ (TO_CNT_W == 0);
`endif

   // State register. Reset returns the FSM to IDLE and abandons any
   // transaction in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and per-state control. An rvalid counts as unsolicited when
   // the FSM is not in WAIT and no drop is pending. That includes an rvalid
   // in the same cycle as gnt while still in REQ. When a real event (gnt or
   // rvalid) coincides with the timeout, the event wins, which keeps the
   // slave and the initiator in step.
   always_comb begin
      w_next_state  = r_state;
      w_cmd_ready   = 1'b0;
      w_obi_req     = 1'b0;
      w_rsp_valid   = 1'b0;
      w_accept      = 1'b0;
      w_rvalid_done = 1'b0;
      w_timeout_hit = 1'b0;
      w_unsolicited = obi_rsp_i.rvalid && !w_absorb && (r_state != WAIT);

      case (r_state)
         IDLE: begin
            w_cmd_ready = 1'b1;
            if (cmd_valid_i) begin
               w_accept     = 1'b1;
               w_next_state = w_range_err ? RSP : REQ;
            end
         end
         REQ: begin
            w_obi_req = 1'b1;
            if (obi_rsp_i.gnt) begin
               w_next_state = WAIT;
            end else if (w_to_expired) begin
               w_timeout_hit = 1'b1;
               w_next_state  = RSP;
            end
         end
         WAIT: begin
            if (obi_rsp_i.rvalid && !w_absorb) begin
               w_rvalid_done = 1'b1;
               w_next_state  = RSP;
            end else if (w_to_expired) begin
               w_timeout_hit = 1'b1;
               w_next_state  = RSP;
            end
         end
         RSP: begin
            w_rsp_valid = 1'b1;
            if (rsp_ready_i) begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Command fields are captured at the handshake and stay fixed until the
   // next one, so the A channel is stable while REQ waits for gnt. The
   // response registers get 0/1 on a local range error or a timeout. From a
   // slave response they get the data, forced to 0 for writes and for
   // errored reads.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_we        <= 1'b0;
         r_offset    <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_we     <= cmd_we_i;
            r_offset <= cmd_offset_i;
            r_wdata  <= cmd_wdata_i;
            r_be     <= cmd_be_i;
         end
         if (w_accept && w_range_err) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
         end else if (w_rvalid_done) begin
            r_rdata <= (r_we || obi_rsp_i.r.err) ? 32'h0 : obi_rsp_i.r.rdata;
            r_err   <= obi_rsp_i.r.err;
         end else if (w_timeout_hit) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
         end
         if (w_unsolicited) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   // The OBI request and the command ready are gated by reset, so asserting
   // reset in the middle of a transaction drops req in that same cycle. The A
   // fields read 0 whenever no request is presented.
   always_comb begin
      obi_req_o         = '0;
      obi_req_o.req     = w_obi_req && !rst_i;
      if (obi_req_o.req) begin
         obi_req_o.a.addr  = EU_BASE_ADDR + r_offset;
         obi_req_o.a.we    = r_we;
         obi_req_o.a.be    = r_be;
         obi_req_o.a.wdata = r_we ? r_wdata : 32'h0;
      end
   end

   assign cmd_ready_o = w_cmd_ready && !rst_i;
   assign rsp_valid_o = w_rsp_valid;
   assign rsp_rdata_o = w_rsp_valid ? r_rdata : 32'h0;
   assign rsp_err_o   = w_rsp_valid && r_err;
   assign proto_err_o = r_proto_err;

endmodule
